// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Function : Multi-cycle FETCH/DECODE/EXE/MEM/WB sequencer for the MIPS datapath.
//            Optional macro MC_ILLEGAL_TRAP_EN: undefined instructions enter HALT.
// Revision : 1.0
// ============================================================================
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        br_take,
    input  logic        dm_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        grf_we,
    output logic        dm_req,
    output logic        dm_we,
    output logic [2:0]  npc_sel,
    output logic        ext_op,
    output logic [1:0]  gwd_sel,
    output logic [1:0]  a3_sel,
    output logic [1:0]  srcb_sel,
    output logic [3:0]  alu_ctrl,
    output logic [2:0]  dm_sel,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic [31:0] instret,
    output logic        mem_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BGTZ  = 6'h07;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LB    = 6'h20;
    localparam logic [5:0] c_OP_LH    = 6'h21;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_LBU   = 6'h24;
    localparam logic [5:0] c_OP_LHU   = 6'h25;
    localparam logic [5:0] c_OP_SB    = 6'h28;
    localparam logic [5:0] c_OP_SH    = 6'h29;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_instret;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_to_cnt;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_unused_bits;
    logic       w_rtype, w_addu, w_subu, w_sll, w_jr;
    logic       w_ori, w_lui, w_slti, w_beq, w_bgtz, w_j, w_jal;
    logic       w_lw, w_lh, w_lhu, w_lb, w_lbu, w_sw, w_sh, w_sb;
    logic       w_load, w_store, w_branch, w_alu;
    logic       w_timeout;
    logic       w_pc_we, w_ir_we, w_grf_we, w_dm_req, w_dm_we, w_done;
    logic [2:0] w_npc_dec;

    assign w_op          = instr[31:26];
    assign w_funct       = instr[5:0];
    assign w_unused_bits = ^instr[25:6];

    assign w_rtype = (w_op == c_OP_RTYPE);
    assign w_addu  = w_rtype && (w_funct == c_FN_ADDU);
    assign w_subu  = w_rtype && (w_funct == c_FN_SUBU);
    assign w_sll   = w_rtype && (w_funct == c_FN_SLL);
    assign w_jr    = w_rtype && (w_funct == c_FN_JR);
    assign w_ori   = (w_op == c_OP_ORI);
    assign w_lui   = (w_op == c_OP_LUI);
    assign w_slti  = (w_op == c_OP_SLTI);
    assign w_beq   = (w_op == c_OP_BEQ);
    assign w_bgtz  = (w_op == c_OP_BGTZ);
    assign w_j     = (w_op == c_OP_J);
    assign w_jal   = (w_op == c_OP_JAL);
    assign w_lw    = (w_op == c_OP_LW);
    assign w_lh    = (w_op == c_OP_LH);
    assign w_lhu   = (w_op == c_OP_LHU);
    assign w_lb    = (w_op == c_OP_LB);
    assign w_lbu   = (w_op == c_OP_LBU);
    assign w_sw    = (w_op == c_OP_SW);
    assign w_sh    = (w_op == c_OP_SH);
    assign w_sb    = (w_op == c_OP_SB);

    assign w_load   = w_lw | w_lh | w_lhu | w_lb | w_lbu;
    assign w_store  = w_sw | w_sh | w_sb;
    assign w_branch = w_beq | w_bgtz;
    assign w_alu    = w_addu | w_subu | w_sll | w_ori | w_lui | w_slti;

    // Datapath selects depend only on the latched instruction.
    always_comb begin
        w_npc_dec = 3'd0;
        ext_op    = 1'b0;
        gwd_sel   = 2'd0;
        a3_sel    = 2'd0;
        srcb_sel  = 2'd0;
        alu_ctrl  = 4'd0;
        dm_sel    = 3'd0;
        if (w_beq)  w_npc_dec = 3'd1;
        if (w_j || w_jal) w_npc_dec = 3'd2;
        if (w_jr)   w_npc_dec = 3'd3;
        if (w_bgtz) w_npc_dec = 3'd4;
        if (w_slti || w_load || w_store) ext_op = 1'b1;
        if (w_load) gwd_sel = 2'd1;
        if (w_jal)  gwd_sel = 2'd2;
        if (w_ori || w_lui || w_slti || w_load) a3_sel = 2'd1;
        if (w_jal)  a3_sel = 2'd2;
        if (w_ori || w_lui || w_slti || w_load || w_store) srcb_sel = 2'd1;
        if (w_subu) alu_ctrl = 4'd1;
        if (w_ori)  alu_ctrl = 4'd2;
        if (w_beq)  alu_ctrl = 4'd3;
        if (w_lui)  alu_ctrl = 4'd4;
        if (w_sll)  alu_ctrl = 4'd5;
        if (w_slti) alu_ctrl = 4'd6;
        if (w_bgtz) alu_ctrl = 4'd9;
        if (w_lh || w_sh) dm_sel = 3'd1;
        if (w_lb || w_sb) dm_sel = 3'd2;
        if (w_lhu)  dm_sel = 3'd3;
        if (w_lbu)  dm_sel = 3'd4;
    end

    // The previous IR is still visible during FETCH, so force sequential PC there.
    assign npc_sel = (r_state == S_FETCH) ? 3'd0 : w_npc_dec;

    assign w_timeout = (MEM_TIMEOUT != 0) && (r_state == S_MEM) && !dm_ready
                       && (r_to_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_we     = 1'b0;
        w_ir_we     = 1'b0;
        w_grf_we    = 1'b0;
        w_dm_req    = 1'b0;
        w_dm_we     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_we     = 1'b1;
                w_pc_we     = 1'b1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_j || w_jal) begin
                    w_pc_we     = 1'b1;
                    w_grf_we    = w_jal;
                    w_done      = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (w_jr) begin
                    w_pc_we     = 1'b1;
                    w_done      = 1'b1;
                    w_state_nxt = S_FETCH;
                end
`ifdef MC_ILLEGAL_TRAP_EN
                else if (!(w_alu || w_load || w_store || w_branch)) begin
                    w_state_nxt = S_HALT;
                end
`endif
                else begin
                    w_state_nxt = S_EXE;
                end
            end
            S_EXE: begin
                if (w_branch) begin
                    w_pc_we     = br_take;
                    w_done      = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (w_load || w_store) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                w_dm_req = 1'b1;
                w_dm_we  = w_store;
                if (dm_ready) begin
                    w_done      = w_store;
                    w_state_nxt = w_store ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_WB: begin
                // Undefined instructions reach WB as a NOP and never write the GRF.
                w_grf_we    = w_alu | w_load;
                w_done      = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_instret <= 32'd0;
            r_mem_err <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_done) begin
                r_instret <= r_instret + 32'd1;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
            if ((MEM_TIMEOUT != 0) && (r_state == S_MEM) && !dm_ready && !w_timeout) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign pc_we      = reset & w_pc_we;
    assign ir_we      = reset & w_ir_we;
    assign grf_we     = reset & w_grf_we;
    assign dm_req     = reset & w_dm_req;
    assign dm_we      = reset & w_dm_we;
    assign instr_done = reset & w_done;
    assign state      = r_state;
    assign instret    = r_instret;
    assign mem_err    = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Function : Directed, table-driven self-checking bench for mc_ctrl.
// Revision : 1.0
// ============================================================================
module tb_mc_ctrl;

    localparam logic [31:0] ADDU = 32'h00221821;
    localparam logic [31:0] SUBU = 32'h00221823;
    localparam logic [31:0] SLL  = 32'h00021080;
    localparam logic [31:0] ORI  = 32'h3422FFFF;
    localparam logic [31:0] LUI  = 32'h3C011234;
    localparam logic [31:0] SLTI = 32'h2822FFFF;
    localparam logic [31:0] BEQ  = 32'h10220001;
    localparam logic [31:0] BGTZ = 32'h1C200003;
    localparam logic [31:0] J    = 32'h08000004;
    localparam logic [31:0] JAL  = 32'h0C000004;
    localparam logic [31:0] JR   = 32'h03E00008;
    localparam logic [31:0] LW   = 32'h8C220004;
    localparam logic [31:0] LH   = 32'h84220000;
    localparam logic [31:0] LHU  = 32'h94220002;
    localparam logic [31:0] LB   = 32'h80220000;
    localparam logic [31:0] LBU  = 32'h90220000;
    localparam logic [31:0] SW   = 32'hAC220004;
    localparam logic [31:0] SH   = 32'hA4220000;
    localparam logic [31:0] SB   = 32'hA0220003;
    localparam logic [31:0] ILL  = 32'hFC000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        br_take;
    logic        dm_ready;
    logic        pc_we, ir_we, grf_we, dm_req, dm_we, ext_op, instr_done, mem_err;
    logic [2:0]  npc_sel, dm_sel, state;
    logic [1:0]  gwd_sel, a3_sel, srcb_sel;
    logic [3:0]  alu_ctrl;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_err = 0;

    mc_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .instr(instr), .br_take(br_take), .dm_ready(dm_ready),
        .pc_we(pc_we), .ir_we(ir_we), .grf_we(grf_we), .dm_req(dm_req), .dm_we(dm_we),
        .npc_sel(npc_sel), .ext_op(ext_op), .gwd_sel(gwd_sel), .a3_sel(a3_sel),
        .srcb_sel(srcb_sel), .alu_ctrl(alu_ctrl), .dm_sel(dm_sel), .state(state),
        .instr_done(instr_done), .instret(instret), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [1:0]  gwd, a3, srcb;
        logic [3:0]  alu;
        logic [2:0]  dmsel;
        logic        ext;
    } sel_t;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        bt, rdy;
        logic [2:0]  st;
        logic        pc, ir, grf, req, we;
        logic [2:0]  npc;
        logic        done;
        logic [31:0] ret;
    } cyc_t;

    sel_t sel_tab[$];
    cyc_t cyc_tab[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later.
    task automatic drive(input logic r, input logic [31:0] ins, input logic bt, input logic rdy);
        @(negedge clk);
        reset    = r;
        instr    = ins;
        br_take  = bt;
        dm_ready = rdy;
        #2;
    endtask

    task automatic add_sel(input logic [31:0] ins, input logic [1:0] gwd, input logic [1:0] a3,
                           input logic [1:0] srcb, input logic [3:0] alu, input logic [2:0] dmsel,
                           input logic ext);
        sel_tab.push_back('{ins, gwd, a3, srcb, alu, dmsel, ext});
    endtask

    task automatic add(input logic rst, input logic [31:0] ins, input logic bt, input logic rdy,
                       input logic [2:0] st, input logic pc, input logic ir, input logic grf,
                       input logic req, input logic we, input logic [2:0] npc, input logic done,
                       input logic [31:0] ret);
        cyc_tab.push_back('{rst, ins, bt, rdy, st, pc, ir, grf, req, we, npc, done, ret});
    endtask

    initial begin
        reset = 1'b0; instr = 32'd0; br_take = 1'b0; dm_ready = 1'b0;

        //       ins   gwd a3 srcb alu dm ext
        add_sel(ADDU, 0, 0, 0, 0, 0, 0);
        add_sel(SUBU, 0, 0, 0, 1, 0, 0);
        add_sel(SLL,  0, 0, 0, 5, 0, 0);
        add_sel(ORI,  0, 1, 1, 2, 0, 0);
        add_sel(LUI,  0, 1, 1, 4, 0, 0);
        add_sel(SLTI, 0, 1, 1, 6, 0, 1);
        add_sel(BEQ,  0, 0, 0, 3, 0, 0);
        add_sel(BGTZ, 0, 0, 0, 9, 0, 0);
        add_sel(JAL,  2, 2, 0, 0, 0, 0);
        add_sel(LW,   1, 1, 1, 0, 0, 1);
        add_sel(LH,   1, 1, 1, 0, 1, 1);
        add_sel(LHU,  1, 1, 1, 0, 3, 1);
        add_sel(LB,   1, 1, 1, 0, 2, 1);
        add_sel(LBU,  1, 1, 1, 0, 4, 1);
        add_sel(SW,   0, 0, 1, 0, 0, 1);
        add_sel(SH,   0, 0, 1, 0, 1, 1);
        add_sel(SB,   0, 0, 1, 0, 2, 1);
        add_sel(ILL,  0, 0, 0, 0, 0, 0);

        //  rst ins  bt rdy st pc ir grf req we npc done ret
        add(0, ADDU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, ADDU, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, ADDU, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, ADDU, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, ADDU, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 0);
        add(1, LW,   0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        add(1, LW,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, LW,   0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, LW,   0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 1);
        add(1, LW,   0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 1);
        add(1, LW,   0, 1, 3, 0, 0, 0, 1, 0, 0, 0, 1);
        add(1, LW,   0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 1);
        add(1, SW,   0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2);
        add(1, SW,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2);
        add(1, SW,   0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 2);
        add(1, SW,   0, 1, 3, 0, 0, 0, 1, 1, 0, 1, 2);
        add(1, BEQ,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3);
        add(1, BEQ,  0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3);
        add(1, BEQ,  1, 0, 2, 1, 0, 0, 0, 0, 1, 1, 3);
        add(1, BEQ,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 4);
        add(1, BEQ,  0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 4);
        add(1, BEQ,  0, 0, 2, 0, 0, 0, 0, 0, 1, 1, 4);
        add(1, JAL,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5);
        add(1, JAL,  0, 0, 1, 1, 0, 1, 0, 0, 2, 1, 5);
        add(1, J,    0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 6);
        add(1, J,    0, 0, 1, 1, 0, 0, 0, 0, 2, 1, 6);
        add(1, BGTZ, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 7);
        add(1, BGTZ, 0, 0, 1, 0, 0, 0, 0, 0, 4, 0, 7);
        add(1, BGTZ, 1, 0, 2, 1, 0, 0, 0, 0, 4, 1, 7);
        add(1, JR,   0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 8);
        add(1, JR,   0, 0, 1, 1, 0, 0, 0, 0, 3, 1, 8);
        add(1, ORI,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 9);
        add(1, ORI,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 9);
        add(1, ORI,  1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 9);
        add(1, ORI,  0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 9);
        add(1, LHU,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 10);
        add(1, LHU,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 10);
        add(1, LHU,  0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 10);
        add(1, LHU,  0, 1, 3, 0, 0, 0, 1, 0, 0, 0, 10);
        add(1, LHU,  0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 10);
        add(1, SB,   0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 11);
        add(1, SB,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 11);
        add(1, SB,   0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 11);
        add(1, SB,   0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 11);
        add(1, SB,   0, 1, 3, 0, 0, 0, 1, 1, 0, 1, 11);
        add(1, ADDU, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 12);

        drive(0, 32'd0, 0, 0);
        drive(0, 32'd0, 0, 0);

        foreach (sel_tab[i]) begin
            drive(0, sel_tab[i].ins, 0, 0);
            chk($sformatf("sel%0d.gwd_sel", i),  gwd_sel,  sel_tab[i].gwd);
            chk($sformatf("sel%0d.a3_sel", i),   a3_sel,   sel_tab[i].a3);
            chk($sformatf("sel%0d.srcb_sel", i), srcb_sel, sel_tab[i].srcb);
            chk($sformatf("sel%0d.alu_ctrl", i), alu_ctrl, sel_tab[i].alu);
            chk($sformatf("sel%0d.dm_sel", i),   dm_sel,   sel_tab[i].dmsel);
            chk($sformatf("sel%0d.ext_op", i),   ext_op,   sel_tab[i].ext);
        end

        chk("reset.mem_err", mem_err, 0);
        foreach (cyc_tab[i]) begin
            drive(cyc_tab[i].rst, cyc_tab[i].ins, cyc_tab[i].bt, cyc_tab[i].rdy);
            chk($sformatf("v%0d.state", i),      state,      cyc_tab[i].st);
            chk($sformatf("v%0d.pc_we", i),      pc_we,      cyc_tab[i].pc);
            chk($sformatf("v%0d.ir_we", i),      ir_we,      cyc_tab[i].ir);
            chk($sformatf("v%0d.grf_we", i),     grf_we,     cyc_tab[i].grf);
            chk($sformatf("v%0d.dm_req", i),     dm_req,     cyc_tab[i].req);
            chk($sformatf("v%0d.dm_we", i),      dm_we,      cyc_tab[i].we);
            chk($sformatf("v%0d.npc_sel", i),    npc_sel,    cyc_tab[i].npc);
            chk($sformatf("v%0d.instr_done", i), instr_done, cyc_tab[i].done);
            chk($sformatf("v%0d.instret", i),    instret,    cyc_tab[i].ret);
        end

        // Finish the trailing addu from the table.
        drive(1, ADDU, 0, 0);
        drive(1, ADDU, 0, 0);
        drive(1, ADDU, 0, 0);
        chk("addu2.done", instr_done, 1);

        // lw with dm_ready stuck low: abort on the 15th MEM cycle.
        drive(1, LW, 0, 0);
        chk("to.fetch", state, 0);
        chk("to.instret", instret, 13);
        drive(1, LW, 0, 0);
        drive(1, LW, 0, 0);
        chk("to.exe", state, 2);
        for (int k = 1; k <= 15; k++) begin
            drive(1, LW, 0, 0);
            chk($sformatf("to.mem%0d.state", k),   state,      3);
            chk($sformatf("to.mem%0d.dm_req", k),  dm_req,     1);
            chk($sformatf("to.mem%0d.grf_we", k),  grf_we,     0);
            chk($sformatf("to.mem%0d.done", k),    instr_done, (k == 15) ? 1 : 0);
            chk($sformatf("to.mem%0d.mem_err", k), mem_err,    0);
        end
        drive(1, LW, 0, 0);
        chk("to.after.state", state, 0);
        chk("to.after.mem_err", mem_err, 1);
        chk("to.after.grf_we", grf_we, 0);
        chk("to.after.instret", instret, 14);

        // Reset asserted mid-MEM drops the request immediately.
        drive(1, LW, 0, 0);
        drive(1, LW, 0, 0);
        drive(1, LW, 0, 0);
        chk("rm.mem", state, 3);
        chk("rm.req_before", dm_req, 1);
        drive(0, LW, 0, 0);
        chk("rm.dm_req", dm_req, 0);
        chk("rm.done", instr_done, 0);
        chk("rm.pc_we", pc_we, 0);
        drive(1, ILL, 0, 0);
        chk("rm.state", state, 0);
        chk("rm.mem_err", mem_err, 0);
        chk("rm.instret", instret, 0);
        chk("rm.ir_we", ir_we, 1);

        // Undefined opcode.
        drive(1, ILL, 0, 0);
        chk("ill.decode", state, 1);
        chk("ill.decode.pc_we", pc_we, 0);
`ifdef MC_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            drive(1, ILL, 0, 1);
            chk($sformatf("ill.halt%0d.state", k), state, 5);
            chk($sformatf("ill.halt%0d.pc_we", k), pc_we, 0);
            chk($sformatf("ill.halt%0d.ir_we", k), ir_we, 0);
            chk($sformatf("ill.halt%0d.done", k), instr_done, 0);
            chk($sformatf("ill.halt%0d.instret", k), instret, 0);
        end
`else
        drive(1, ILL, 0, 0);
        chk("ill.exe", state, 2);
        drive(1, ILL, 0, 0);
        chk("ill.wb", state, 4);
        chk("ill.wb.grf_we", grf_we, 0);
        chk("ill.wb.done", instr_done, 1);
        drive(1, ADDU, 0, 0);
        chk("ill.fetch", state, 0);
        chk("ill.instret", instret, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath. It replaces per-instruction combinational decode with an FSM that steps each instruction through FETCH/DECODE/EXE/MEM/WB. Write enables (PC, IR, GRF, DM) are asserted only in the correct state, and the data-memory handshake is honoured. Mux and ALU selects are decoded from the latched IR value and use the existing datapath encodings.

Parameters:
- MEM_TIMEOUT, 15, maximum MEM-state wait cycles before forced abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the clk rising edge.
- instr  in  32  IR register output (the latched instruction).
- br_take  in  1  comparator result for the current beq/bgtz, valid in EXE.
- dm_ready  in  1  data memory completes the access this cycle.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- grf_we  out  1  register file write enable.
- dm_req  out  1  data memory request.
- dm_we  out  1  data memory write enable.
- npc_sel  out  3  next-PC select: 0 = PC+4, 1 = beq target, 2 = j/jal target, 3 = jr register, 4 = bgtz target.
- ext_op  out  1  1 = sign-extend, 0 = zero-extend.
- gwd_sel  out  2  GRF write data: 0 = ALUOut, 1 = MDR, 2 = saved PC+4.
- a3_sel  out  2  write register: 0 = rd, 1 = rt, 2 = $31.
- srcb_sel  out  2  ALU B input: 0 = rt data, 1 = extended immediate.
- alu_ctrl  out  4  0 = add, 1 = sub, 2 = or, 3 = eq-compare, 4 = lui, 5 = sll, 6 = slt, 9 = gtz.
- dm_sel  out  3  width: 0 = word, 1 = half, 3 = half unsigned, 2 = byte, 4 = byte unsigned.
- state  out  3  FSM state: 0 = FETCH, 1 = DECODE, 2 = EXE, 3 = MEM, 4 = WB, 5 = HALT.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- instret  out  32  count of retired instructions.
- mem_err  out  1  sticky; set when a MEM timeout occurs.

Behaviour:
- Supported instructions: addu, subu, sll, jr, ori, lui, slti, beq, bgtz, j, jal, lw, sw, lh, lhu, sh, lb, lbu, sb.
- Select outputs are pure combinational decode of `instr`, independent of state. Unused selects are 0.
- Enables are decoded from state and instruction, then ANDed with reset.
- Reset (reset == 0 at a clock edge):
  - state ← FETCH, instret ← 0, mem_err ← 0, timeout counter ← 0.
  - All enables, dm_req and instr_done are 0 while reset is low.
  - Reset during MEM abandons the access; dm_req drops in the same cycle.
- FETCH: ir_we = 1, pc_we = 1, npc_sel = 0. Next state DECODE.
- DECODE:
  - j: pc_we = 1, npc_sel = 2, instr_done. Next state FETCH.
  - jal: same as j, plus grf_we = 1, a3_sel = 2, gwd_sel = 2.
  - jr: pc_we = 1, npc_sel = 3, instr_done. Next state FETCH.
  - All other instructions: next state EXE.
- EXE:
  - beq/bgtz: pc_we = br_take, instr_done. Next state FETCH.
  - Loads and stores: next state MEM.
  - ALU instructions: next state WB.
- MEM:
  - dm_req = 1; dm_we = 1 for stores.
  - Stays in MEM until dm_ready.
  - On dm_ready: a store retires (instr_done) and goes to FETCH; a load goes to WB.
  - dm_ready in the same cycle MEM is entered counts; minimum MEM residency is 1 cycle.
  - Timeout counter counts MEM cycles without dm_ready.
  - When the count reaches MEM_TIMEOUT: mem_err ← 1, instruction retires without a GRF write, next state FETCH.
- WB: grf_we = 1, instr_done. Next state FETCH.
- instret increments by 1 in every cycle where instr_done = 1 and wraps 0xFFFFFFFF → 0.
- Latency in cycles: j/jal/jr 2, branch 3, ALU 4, store 3+wait, load 4+wait.
- Undefined opcode/funct without the optional feature: treated as NOP. It passes DECODE → EXE → WB with grf_we forced 0, then retires.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: an undefined instruction in DECODE goes to HALT.
  - HALT holds until reset; all enables are 0.
  - The instruction does not retire.
- Undefined: undefined instructions behave as a NOP (4 cycles, retired), and state 5 is unreachable.

Test Plan:
- Reset then addu 0x00221821, dm_ready = 0 → states 0, 1, 2, 4.
  - grf_we = 1 only in WB, with a3_sel = 0, alu_ctrl = 0.
  - instret = 1 after the WB cycle.
- lw 0x8C220004 with dm_ready delayed 2 cycles → MEM held 3 cycles with dm_req = 1, dm_we = 0.
  - Then WB with gwd_sel = 1, a3_sel = 1; total 7 cycles.
- sw 0xAC220004 with dm_ready = 1 on MEM entry → dm_we = 1 for 1 cycle, instr_done in MEM, back to FETCH.
- beq 0x10220001 with br_take = 1 → pc_we = 1, npc_sel = 1 in EXE.
  - Repeat with br_take = 0 → pc_we = 0; instret increments both times.
- jal 0x0C000004 → DECODE has pc_we = 1, grf_we = 1, npc_sel = 2, a3_sel = 2, gwd_sel = 2; 2 cycles total.
- lw with dm_ready stuck 0, MEM_TIMEOUT = 15 → mem_err = 1 after 15 MEM cycles, no grf_we, next state FETCH.
  - Separately: reset low mid-MEM → dm_req = 0 the same cycle, state = 0.
  - Separately: 0xFC000000 with MC_ILLEGAL_TRAP_EN → state = 5 and held.
